playfield_renderer: RTL and testbench



---
 rtl/playfield_renderer.sv | 187 ++++++++++++++++++
 tb/tb_playfield_renderer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/playfield_renderer.sv
// rtl/playfield_renderer.sv - Tetris playfield cell store, clear sequencer and 2-stage pixel renderer
// Optional build macro: GRID_LINES_EN (grey cell-edge grid on empty cells)
module playfield_renderer #(
    parameter int COLS     = 10,
    parameter int ROWS     = 22,
    parameter int CELL_PX  = 20,
    parameter int ORIGIN_X = 220,
    parameter int ORIGIN_Y = 20
) (
    input  logic       iCLK,
    input  logic       iRST,
    input  logic [9:0] iPx,
    input  logic [9:0] iPy,
    input  logic       iWr_en,
    input  logic [3:0] iWr_col,
    input  logic [4:0] iWr_row,
    input  logic [2:0] iWr_code,
    input  logic [3:0] iRd_col,
    input  logic [4:0] iRd_row,
    output logic [2:0] oRd_code,
    input  logic       iClear,
    output logic       oBusy,
    output logic [3:0] oRed,
    output logic [3:0] oGreen,
    output logic [3:0] oBlue
);
    localparam int CELLS = COLS * ROWS;
    localparam int IW    = $clog2(CELLS);

    typedef enum logic {S_IDLE, S_CLEAR} state_t;

    state_t        r_state, w_state_nxt;
    logic [IW-1:0] r_clr_idx, w_clr_idx_nxt;
    logic          w_busy;
    logic [2:0]    r_cells [CELLS];

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_state   <= S_CLEAR;
            r_clr_idx <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_idx <= w_clr_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_clr_idx_nxt = r_clr_idx;
        w_busy        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (iClear) begin
                    w_state_nxt   = S_CLEAR;
                    w_clr_idx_nxt = '0;
                end
            end
            S_CLEAR: begin
                w_busy        = 1'b1;
                w_clr_idx_nxt = r_clr_idx + 1'b1;
                if (r_clr_idx == IW'(CELLS - 1)) begin
                    w_state_nxt   = S_IDLE;
                    w_clr_idx_nxt = '0;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign oBusy = w_busy;

    logic          w_wr_ok, w_rd_ok;
    logic [IW-1:0] w_wr_idx, w_rd_idx;

    assign w_wr_ok  = iWr_en && !w_busy && (iWr_col < 4'(COLS)) && (iWr_row < 5'(ROWS));
    assign w_wr_idx = IW'(iWr_row) * IW'(COLS) + IW'(iWr_col);
    assign w_rd_ok  = (iRd_col < 4'(COLS)) && (iRd_row < 5'(ROWS));
    assign w_rd_idx = IW'(iRd_row) * IW'(COLS) + IW'(iRd_col);

    // The clearing sequencer owns the write port; logic writes are dropped meanwhile.
    always_ff @(posedge iCLK) begin
        if (w_busy)
            r_cells[r_clr_idx] <= 3'd0;
        else if (w_wr_ok)
            r_cells[w_wr_idx] <= iWr_code;
    end

    logic [2:0] r_rd_code;
    always_ff @(posedge iCLK) begin
        if (iRST)
            r_rd_code <= 3'd0;
        else
            r_rd_code <= w_rd_ok ? r_cells[w_rd_idx] : 3'd0;
    end
    assign oRd_code = r_rd_code;

    // Stage 1: field test and cell coordinates via compare chains instead of a divider.
    logic       w_in;
    logic [9:0] w_dx, w_dy;
    logic [3:0] w_col;
    logic [4:0] w_row;
    logic       r_s1_in;
    logic [3:0] r_s1_col;
    logic [4:0] r_s1_row;

    assign w_in = (iPx >= 10'(ORIGIN_X)) && (iPx < 10'(ORIGIN_X + COLS * CELL_PX)) &&
                  (iPy >= 10'(ORIGIN_Y)) && (iPy < 10'(ORIGIN_Y + ROWS * CELL_PX));
    assign w_dx = w_in ? (iPx - 10'(ORIGIN_X)) : 10'd0;
    assign w_dy = w_in ? (iPy - 10'(ORIGIN_Y)) : 10'd0;

    always_comb begin
        w_col = 4'd0;
        w_row = 5'd0;
        for (int k = 1; k < COLS; k++)
            if (w_dx >= 10'(k * CELL_PX)) w_col = 4'(k);
        for (int k = 1; k < ROWS; k++)
            if (w_dy >= 10'(k * CELL_PX)) w_row = 5'(k);
    end

`ifdef GRID_LINES_EN
    logic w_edge, r_s1_edge;
    always_comb begin
        w_edge = 1'b0;
        for (int k = 0; k < COLS; k++)
            if (w_dx == 10'(k * CELL_PX)) w_edge = 1'b1;
        for (int k = 0; k < ROWS; k++)
            if (w_dy == 10'(k * CELL_PX)) w_edge = 1'b1;
    end
    always_ff @(posedge iCLK) begin
        if (iRST) r_s1_edge <= 1'b0;
        else      r_s1_edge <= w_edge;
    end
`endif

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_s1_in  <= 1'b0;
            r_s1_col <= 4'd0;
            r_s1_row <= 5'd0;
        end else begin
            r_s1_in  <= w_in;
            r_s1_col <= w_col;
            r_s1_row <= w_row;
        end
    end

    function automatic logic [11:0] palette(input logic [2:0] code);
        case (code)
            3'd1:    palette = 12'h0FF;
            3'd2:    palette = 12'hFF0;
            3'd3:    palette = 12'hA0F;
            3'd4:    palette = 12'h0F0;
            3'd5:    palette = 12'hF00;
            3'd6:    palette = 12'h00F;
            3'd7:    palette = 12'hFA0;
            default: palette = 12'h000;
        endcase
    endfunction

    // Stage 2: the cell lookup sees any write committed on the edge that loaded stage 1.
    logic [IW-1:0] w_rnd_idx;
    logic [2:0]    w_rnd_code;
    logic [11:0]   w_rgb;
    logic [11:0]   r_rgb;

    assign w_rnd_idx  = IW'(r_s1_row) * IW'(COLS) + IW'(r_s1_col);
    assign w_rnd_code = r_cells[w_rnd_idx];

    always_comb begin
        w_rgb = 12'h000;
        if (r_s1_in) begin
            w_rgb = palette(w_rnd_code);
`ifdef GRID_LINES_EN
            if (w_rnd_code == 3'd0 && r_s1_edge) w_rgb = 12'h444;
`endif
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) r_rgb <= 12'h000;
        else      r_rgb <= w_rgb;
    end

    assign oRed   = r_rgb[11:8];
    assign oGreen = r_rgb[7:4];
    assign oBlue  = r_rgb[3:0];
endmodule

// File: tb/tb_playfield_renderer.sv
// tb/tb_playfield_renderer.sv - scoreboard bench for playfield_renderer (directed vectors)
module tb_playfield_renderer;
    logic       iCLK = 1'b0;
    logic       iRST;
    logic [9:0] iPx, iPy;
    logic       iWr_en;
    logic [3:0] iWr_col;
    logic [4:0] iWr_row;
    logic [2:0] iWr_code;
    logic [3:0] iRd_col;
    logic [4:0] iRd_row;
    logic [2:0] oRd_code;
    logic       iClear;
    logic       oBusy;
    logic [3:0] oRed, oGreen, oBlue;

    always #5 iCLK = ~iCLK;

    playfield_renderer dut (
        .iCLK(iCLK), .iRST(iRST), .iPx(iPx), .iPy(iPy),
        .iWr_en(iWr_en), .iWr_col(iWr_col), .iWr_row(iWr_row), .iWr_code(iWr_code),
        .iRd_col(iRd_col), .iRd_row(iRd_row), .oRd_code(oRd_code),
        .iClear(iClear), .oBusy(oBusy),
        .oRed(oRed), .oGreen(oGreen), .oBlue(oBlue)
    );

`ifdef GRID_LINES_EN
    localparam logic [11:0] GRID_RGB = 12'h444;
`else
    localparam logic [11:0] GRID_RGB = 12'h000;
`endif

    int          checks = 0;
    int          failures = 0;
    logic [11:0] pix_q[$];
    logic [2:0]  rd_q[$];
    logic        pix_req = 1'b0, rd_req = 1'b0;
    logic        pv1 = 1'b0, pv2 = 1'b0, rv1 = 1'b0;
    logic [11:0] mon_pe;
    logic [2:0]  mon_re;

    always @(posedge iCLK) begin
        pv1 <= pix_req;
        pv2 <= pv1;
        rv1 <= rd_req;
    end

    always @(negedge iCLK) begin
        if (pv2) begin
            checks++;
            if (pix_q.size() == 0) begin
                failures++;
                $display("FAIL pixel_sb: output with empty queue, got %h", {oRed, oGreen, oBlue});
            end else begin
                mon_pe = pix_q.pop_front();
                if ({oRed, oGreen, oBlue} !== mon_pe) begin
                    failures++;
                    $display("FAIL pixel_rgb: got %h expected %h", {oRed, oGreen, oBlue}, mon_pe);
                end
            end
        end
        if (rv1) begin
            checks++;
            if (rd_q.size() == 0) begin
                failures++;
                $display("FAIL read_sb: output with empty queue, got %0d", oRd_code);
            end else begin
                mon_re = rd_q.pop_front();
                if (oRd_code !== mon_re) begin
                    failures++;
                    $display("FAIL read_code: got %0d expected %0d", oRd_code, mon_re);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge iCLK);
    endtask

    task automatic check(input string name, input logic [11:0] got, input logic [11:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic write_cell(input int c, input int r, input int code);
        iWr_en = 1'b1; iWr_col = 4'(c); iWr_row = 5'(r); iWr_code = 3'(code);
        tick();
        iWr_en = 1'b0;
    endtask

    task automatic read_req(input int c, input int r, input logic [2:0] exp);
        iRd_col = 4'(c); iRd_row = 5'(r); rd_req = 1'b1;
        rd_q.push_back(exp);
        tick();
        rd_req = 1'b0;
    endtask

    task automatic pix(input int x, input int y, input logic [11:0] exp);
        iPx = 10'(x); iPy = 10'(y); pix_req = 1'b1;
        pix_q.push_back(exp);
        tick();
        pix_req = 1'b0;
    endtask

    task automatic count_busy(output int cnt);
        cnt = 0;
        while (oBusy && cnt < 1000) begin
            cnt++;
            tick();
        end
    endtask

    task automatic read_all_zero();
        for (int r = 0; r < 22; r++)
            for (int c = 0; c < 10; c++)
                read_req(c, r, 3'd0);
    endtask

    int cnt;

    initial begin
        iRST = 1'b1; iPx = 10'd0; iPy = 10'd0; iWr_en = 1'b0; iWr_col = 4'd0; iWr_row = 5'd0;
        iWr_code = 3'd0; iRd_col = 4'd0; iRd_row = 5'd0; iClear = 1'b0;
        repeat (3) tick();
        check("reset_rgb", {oRed, oGreen, oBlue}, 12'h000);
        check("reset_rd_code", 12'(oRd_code), 12'h000);
        check("reset_busy", 12'(oBusy), 12'h001);

        iRST = 1'b0;
        count_busy(cnt);
        check("init_clear_cycles", 12'(cnt), 12'd220);
        read_all_zero();

        write_cell(3, 5, 5);
        pix(290, 130, 12'hF00);
        pix(219, 130, 12'h000);
        pix(420, 130, 12'h000);
        pix(280, 130, 12'hF00);
        pix(419, 130, 12'h000);
        write_cell(0, 0, 3);
        write_cell(1, 1, 2);
        write_cell(2, 2, 4);
        write_cell(4, 4, 6);
        write_cell(5, 10, 7);
        write_cell(9, 21, 1);
        pix(225, 25, 12'hA0F);
        pix(250, 50, 12'hFF0);
        pix(270, 70, 12'h0F0);
        pix(310, 110, 12'h00F);
        pix(330, 235, 12'hFA0);
        pix(419, 459, 12'h0FF);
        pix(419, 460, 12'h000);
        pix(240, 25, GRID_RGB);
        pix(245, 25, 12'h000);
        pix(260, 70, 12'h0F0);

        // Write and render the same cell on one edge: the pixel must see the new code.
        iWr_en = 1'b1; iWr_col = 4'd6; iWr_row = 5'd6; iWr_code = 3'd5;
        pix(350, 150, 12'hF00);
        iWr_en = 1'b0;

        read_req(9, 21, 3'd1);
        write_cell(10, 0, 2);
        read_req(10, 0, 3'd0);
        read_req(0, 0, 3'd3);
        read_req(3, 22, 3'd0);

        iWr_en = 1'b1; iWr_col = 4'd7; iWr_row = 5'd7; iWr_code = 3'd3;
        read_req(7, 7, 3'd0);
        iWr_en = 1'b0;
        read_req(7, 7, 3'd3);

        iClear = 1'b1;
        tick();
        iClear = 1'b0;
        cnt = 0;
        while (oBusy && cnt < 1000) begin
            cnt++;
            if (cnt == 10) begin
                iWr_en = 1'b1; iWr_col = 4'd0; iWr_row = 5'd0; iWr_code = 3'd6;
            end
            if (cnt == 50) iClear = 1'b1;
            if (cnt == 100) begin
                iWr_en = 1'b1; iWr_col = 4'd1; iWr_row = 5'd0; iWr_code = 3'd6;
            end
            tick();
            iWr_en = 1'b0;
            iClear = 1'b0;
        end
        check("clear_cycles", 12'(cnt), 12'd220);
        read_all_zero();

        write_cell(9, 21, 1);
        pix(419, 459, 12'h0FF);
        iClear = 1'b1;
        tick();
        iClear = 1'b0;
        cnt = 0;
        while (oBusy && cnt < 120) begin
            cnt++;
            tick();
        end
        check("busy_before_reset", 12'(cnt), 12'd120);
        iRST = 1'b1; iPx = 10'd419; iPy = 10'd459;
        repeat (3) begin
            tick();
            check("rgb_in_reset", {oRed, oGreen, oBlue}, 12'h000);
        end
        iRST = 1'b0;
        count_busy(cnt);
        check("restart_clear_cycles", 12'(cnt), 12'd220);
        pix(419, 459, 12'h000);
        read_req(9, 21, 3'd0);

        repeat (4) tick();
        check("pix_queue_drained", 12'(pix_q.size()), 12'd0);
        check("rd_queue_drained", 12'(rd_q.size()), 12'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
